// File: rtl/counter_arb_ctrl.sv
// Round-robin sequencer for a loadable up/down counter: grants one count job at a
// time, loads the counter, waits for the target (or a timeout) and parks it there.
module counter_arb_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] start0,
   input  logic [WIDTH-1:0] start1,
   input  logic [WIDTH-1:0] target0,
   input  logic [WIDTH-1:0] target1,
   input  logic             dir0,
   input  logic             dir1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             err,
   output logic             load,
   output logic             mode,
   output logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] dout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Last COUNT cycle before a timeout: the tick counter holds 2**WIDTH-1 there.
   localparam logic [WIDTH:0] TICK_LAST = {1'b0, {WIDTH{1'b1}}};

   state_t           state;
   state_t           state_nx;
   logic             ptr;        // last winner; also owner of the current job
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] target_q;
   logic             dir_q;
   logic [WIDTH-1:0] park_q;
   logic             err_q;
   logic [WIDTH:0]   tick_q;

   logic             pick;
   logic             hit;
   logic             expired;

   // With both requesting, the one not served last wins.
   assign pick    = (req == 2'b11) ? ~ptr : req[1];
   assign hit     = (dout == target_q);
   assign expired = (tick_q == TICK_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr      <= 1'b1;
         start_q  <= '0;
         target_q <= '0;
         dir_q    <= 1'b0;
         park_q   <= '0;
         err_q    <= 1'b0;
         tick_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  ptr      <= pick;
                  start_q  <= pick ? start1  : start0;
                  target_q <= pick ? target1 : target0;
                  dir_q    <= pick ? dir1    : dir0;
               end
            end
            S_LOAD: begin
               tick_q <= '0;
            end
            S_COUNT: begin
               // Only the value on the exit cycle matters: 0 on a hit, 1 on timeout.
               err_q <= ~hit;
               if (!hit) begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            S_DONE: begin
               park_q <= target_q;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      gnt      = 2'b00;
      done     = 2'b00;
      err      = 1'b0;
      load     = 1'b1;
      mode     = 1'b0;
      data_in  = park_q;
      case (state)
         S_IDLE: begin
            if (|req) begin
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            gnt      = {ptr, ~ptr};
            mode     = dir_q;
            data_in  = start_q;
            state_nx = S_COUNT;
         end
         S_COUNT: begin
            gnt     = {ptr, ~ptr};
            load    = 1'b0;
            mode    = dir_q;
            data_in = start_q;
            if (hit || expired) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            // Reloading the target undoes the step taken while DONE was decided.
            gnt      = {ptr, ~ptr};
            done     = {ptr, ~ptr};
            err      = err_q;
            mode     = dir_q;
            data_in  = target_q;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Directed bench for counter_arb_ctrl with a behavioural counter closing the loop
// on dout; each scenario task checks its own hand-computed cycle numbers.
module tb_counter_arb_ctrl;

   localparam int W = 4;

   logic         clk;
   logic         rstn;
   logic [1:0]   req;
   logic [W-1:0] start0, start1, target0, target1;
   logic         dir0, dir1;
   logic [1:0]   gnt;
   logic [1:0]   done;
   logic         err;
   logic         load;
   logic         mode;
   logic [W-1:0] data_in;
   logic [W-1:0] dout;
   logic         stuck;

   int total;
   int bad;

   counter_arb_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .req(req),
      .start0(start0), .start1(start1),
      .target0(target0), .target1(target1),
      .dir0(dir0), .dir1(dir1),
      .gnt(gnt), .done(done), .err(err),
      .load(load), .mode(mode), .data_in(data_in), .dout(dout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // counter model; stuck forces dout to 0 for the timeout scenario
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          dout <= '0;
      else if (stuck)     dout <= '0;
      else if (load)      dout <= data_in;
      else if (mode)      dout <= dout + 1'b1;
      else                dout <= dout - 1'b1;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      req = 2'b00;
      start0 = '0; start1 = '0; target0 = '0; target1 = '0;
      dir0 = 1'b0; dir1 = 1'b0;
      stuck = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   // Called in cycle c0 with req already driven; returns at the done cycle.
   task automatic observe_job(input logic [1:0] req_after, input int limit,
                              output int done_cyc, output int gnt_cyc,
                              output logic [1:0] done_val, output logic err_val,
                              output logic [W-1:0] load_val);
      done_cyc = -1; gnt_cyc = 0; done_val = 2'b00; err_val = 1'b0; load_val = '0;
      for (int c = 1; c <= limit; c++) begin
         tick();
         if (c == 1) begin
            req = req_after;
            load_val = data_in;
         end
         if (gnt != 2'b00) gnt_cyc++;
         if (done != 2'b00) begin
            done_cyc = c;
            done_val = done;
            err_val  = err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req = 2'b11;
      #2;
      total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (load !== 1'b1) begin bad++; $display("FAIL reset_load got=%b exp=1", load); end
      total++; if (data_in !== 4'd0) begin bad++; $display("FAIL reset_data_in got=%0d exp=0", data_in); end
      total++; if (mode !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b exp=0", mode); end
      apply_reset();
   endtask

   task automatic test_up_job();
      int dc, gc; logic [1:0] dv; logic ev; logic [W-1:0] lv;
      apply_reset();
      start0 = 4'd3; target0 = 4'd7; dir0 = 1'b1; req = 2'b01;
      observe_job(2'b00, 40, dc, gc, dv, ev, lv);
      total++; if (dc !== 7) begin bad++; $display("FAIL up_done_cycle got=%0d exp=7", dc); end
      total++; if (gc !== 7) begin bad++; $display("FAIL up_gnt_cycles got=%0d exp=7", gc); end
      total++; if (dv !== 2'b01) begin bad++; $display("FAIL up_done_val got=%b exp=01", dv); end
      total++; if (ev !== 1'b0) begin bad++; $display("FAIL up_err got=%b exp=0", ev); end
      total++; if (lv !== 4'd3) begin bad++; $display("FAIL up_load_val got=%0d exp=3", lv); end
      total++; if (data_in !== 4'd7 || load !== 1'b1) begin bad++; $display("FAIL up_park_load got=%0d/%b exp=7/1", data_in, load); end
      tick();
      total++; if (gnt !== 2'b00 || done !== 2'b00) begin bad++; $display("FAIL up_idle_after got=%b/%b exp=00/00", gnt, done); end
      total++; if (data_in !== 4'd7) begin bad++; $display("FAIL up_park got=%0d exp=7", data_in); end
   endtask

   task automatic test_down_wrap();
      int dc, gc; logic [1:0] dv; logic ev; logic [W-1:0] lv;
      start1 = 4'd2; target1 = 4'd14; dir1 = 1'b0; req = 2'b10;
      observe_job(2'b00, 40, dc, gc, dv, ev, lv);
      total++; if (dc !== 7) begin bad++; $display("FAIL down_done_cycle got=%0d exp=7", dc); end
      total++; if (dv !== 2'b10) begin bad++; $display("FAIL down_done_val got=%b exp=10", dv); end
      total++; if (lv !== 4'd2) begin bad++; $display("FAIL down_load_val got=%0d exp=2", lv); end
      total++; if (mode !== 1'b0) begin bad++; $display("FAIL down_mode got=%b exp=0", mode); end
      tick();
      total++; if (data_in !== 4'd14) begin bad++; $display("FAIL down_park got=%0d exp=14", data_in); end
      total++; if (dout !== 4'd14) begin bad++; $display("FAIL down_dout_parked got=%0d exp=14", dout); end
   endtask

   task automatic test_zero_step();
      int dc, gc; logic [1:0] dv; logic ev; logic [W-1:0] lv;
      start0 = 4'd5; target0 = 4'd5; dir0 = 1'b1; req = 2'b01;
      observe_job(2'b00, 40, dc, gc, dv, ev, lv);
      total++; if (dc !== 3) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=3", dc); end
      total++; if (gc !== 3) begin bad++; $display("FAIL zero_gnt_cycles got=%0d exp=3", gc); end
      total++; if (ev !== 1'b0) begin bad++; $display("FAIL zero_err got=%b exp=0", ev); end
      tick();
   endtask

   task automatic test_timeout();
      int dc, gc; logic [1:0] dv; logic ev; logic [W-1:0] lv;
      stuck = 1'b1;
      start0 = 4'd4; target0 = 4'd9; dir0 = 1'b1; req = 2'b01;
      observe_job(2'b00, 40, dc, gc, dv, ev, lv);
      total++; if (dc !== 18) begin bad++; $display("FAIL timeout_done_cycle got=%0d exp=18", dc); end
      total++; if (gc !== 18) begin bad++; $display("FAIL timeout_gnt_cycles got=%0d exp=18", gc); end
      total++; if (ev !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", ev); end
      total++; if (dv !== 2'b01) begin bad++; $display("FAIL timeout_done_val got=%b exp=01", dv); end
      tick();
      stuck = 1'b0;
      total++; if (err !== 1'b0 || data_in !== 4'd9) begin bad++; $display("FAIL timeout_after got=%b/%0d exp=0/9", err, data_in); end
   endtask

   task automatic test_back_to_back();
      int seq[4];
      int exp_seq[4] = '{0, 1, 0, 1};
      logic [W-1:0] exp_start[4] = '{4'd1, 4'd10, 4'd1, 4'd10};
      int nrec, gap, fin;
      logic [1:0] prev;
      rstn = 1'b0;
      req = 2'b11;
      start0 = 4'd1; target0 = 4'd3; dir0 = 1'b1;
      start1 = 4'd8; target1 = 4'd6; dir1 = 1'b0;
      tick();
      rstn = 1'b1;
      nrec = 0; gap = 0; prev = 2'b00; fin = 0;
      for (int c = 1; c <= 100 && fin == 0; c++) begin
         tick();
         if (gnt != 2'b00 && prev == 2'b00 && nrec < 4) begin
            seq[nrec] = gnt[1] ? 1 : 0;
            total++; if (seq[nrec] !== exp_seq[nrec]) begin bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", nrec, seq[nrec], exp_seq[nrec]); end
            total++; if (data_in !== exp_start[nrec] || load !== 1'b1) begin bad++; $display("FAIL rr_load idx=%0d got=%0d exp=%0d", nrec, data_in, exp_start[nrec]); end
            if (nrec > 0) begin
               total++; if (gap !== 1) begin bad++; $display("FAIL rr_gap idx=%0d got=%0d exp=1", nrec, gap); end
            end
            if (nrec == 0) start1 = 4'd10;
            nrec++;
            gap = 0;
            if (nrec == 4) req = 2'b00;
         end else if (gnt == 2'b00) begin
            gap++;
         end
         if (nrec == 4 && done != 2'b00) begin
            total++; if (done !== 2'b10) begin bad++; $display("FAIL rr_last_done got=%b exp=10", done); end
            fin = 1;
         end
         prev = gnt;
      end
      total++; if (fin !== 1) begin bad++; $display("FAIL rr_complete got=%0d grants exp=4", nrec); end
      tick();
   endtask

   task automatic test_reset_mid();
      int dc, gc; logic [1:0] dv; logic ev; logic [W-1:0] lv;
      apply_reset();
      start0 = 4'd0; target0 = 4'd10; dir0 = 1'b1; req = 2'b01;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) req = 2'b00;
      end
      total++; if (gnt !== 2'b01 || load !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b/%b exp=01/0", gnt, load); end
      rstn = 1'b0;
      #1;
      total++; if (gnt !== 2'b00 || done !== 2'b00) begin bad++; $display("FAIL mid_abort got=%b/%b exp=00/00", gnt, done); end
      total++; if (load !== 1'b1 || data_in !== 4'd0) begin bad++; $display("FAIL mid_outputs got=%b/%0d exp=1/0", load, data_in); end
      tick();
      rstn = 1'b1;
      start0 = 4'd6; target0 = 4'd8; dir0 = 1'b1; req = 2'b01;
      observe_job(2'b00, 40, dc, gc, dv, ev, lv);
      total++; if (dc !== 5) begin bad++; $display("FAIL mid_fresh_cycle got=%0d exp=5", dc); end
      total++; if (dv !== 2'b01 || ev !== 1'b0) begin bad++; $display("FAIL mid_fresh_done got=%b/%b exp=01/0", dv, ev); end
      total++; if (lv !== 4'd6) begin bad++; $display("FAIL mid_fresh_load got=%0d exp=6", lv); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rstn = 1'b0; req = 2'b00; stuck = 1'b0;
      start0 = '0; start1 = '0; target0 = '0; target1 = '0; dir0 = 1'b0; dir1 = 1'b0;
      test_reset();
      test_up_job();
      test_down_wrap();
      test_zero_step();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_arb_ctrl.md
# counter_arb_ctrl

Arbitrating sequencer for the 4-bit loadable up/down counter. Two requesters each submit a count job (start value, target value, direction). The block grants one job at a time, round-robin, and drives the counter's `load`/`mode`/`data_in` controls. It watches `dout` until the target is reached, then reports completion and parks the counter at the target. It sits between the requester logic and the counter, on the same `clk`/`rstn` as the counter interface.

## Interface
Parameters:
- `WIDTH`, default 4: counter data width; timeout limit is 2**WIDTH COUNT cycles.

Ports:
- `clk`  in  1  single clock, all state updates on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester job request, level.
- `start0`, `start1`  in  WIDTH  job start value per requester.
- `target0`, `target1`  in  WIDTH  job target value per requester.
- `dir0`, `dir1`  in  1  job direction per requester; 1 = up, 0 = down.
- `gnt`  out  2  one-hot grant, high for the whole job.
- `done`  out  2  one-cycle completion pulse to the granted requester.
- `err`  out  1  one-cycle timeout flag, coincident with `done`.
- `load`  out  1  counter load enable.
- `mode`  out  1  counter direction; 1 = up, 0 = down.
- `data_in`  out  WIDTH  counter load value.
- `dout`  in  WIDTH  counter output.

## Operation
Counter contract:
- `load`=1: `dout` becomes `data_in` at the next edge.
- `load`=0: `dout` steps ±1 per edge according to `mode`, wrapping mod 2**WIDTH.

FSM states: IDLE, LOAD, COUNT, DONE. State, operand latches, round-robin pointer, park register and 5-bit timeout counter are flops. Outputs are combinational decode of the registered state.

- IDLE:
  - Drives `load`=1, `data_in`=park, `mode`=0, so the counter holds.
  - If any `req` bit is high, picks a winner: the only requester, or the non-pointer requester when both are high.
  - Latches the winner's start, target and dir; sets the pointer to the winner; goes to LOAD.
- LOAD:
  - Drives `load`=1, `data_in`=start, `mode`=dir; `gnt[winner]`=1.
  - Always goes to COUNT; clears the timeout counter.
- COUNT:
  - Drives `load`=0, `mode`=dir; `gnt[winner]`=1.
  - If `dout`==target, goes to DONE with err=0.
  - Otherwise the timeout counter increments. When it reaches 2**WIDTH without a match, goes to DONE with err=1.
- DONE:
  - Drives `load`=1, `data_in`=target, `mode`=dir, so the counter is re-parked after its extra step.
  - `gnt[winner]`=1, `done[winner]`=1, `err`=latched err.
  - Park register becomes target. Goes to IDLE.
- Operands are sampled only in IDLE. Changes afterwards are ignored.
- Dropping `req` mid-job does not abort the job.
- A `req` still high in the IDLE after DONE starts a new job, with the pointer now favouring the other requester.
- Step count N = (target−start) mod 2**WIDTH for up, (start−target) mod 2**WIDTH for down. N ranges 0..2**WIDTH−1, so a healthy counter never times out.

## Timing
- Reset (async, while `rstn`=0):
  - State goes to IDLE, pointer favours requester 0, park=0, latches and timeout counter cleared.
  - Outputs: `gnt`=0, `done`=0, `err`=0, `load`=1, `data_in`=0, `mode`=0.
- Reset mid-job: the job is aborted with no `done`, and `gnt` drops immediately.
- Latency: IDLE sample cycle c0, LOAD c1, COUNT c2..c2+N, DONE c3+N.
  - `done` is high exactly in cycle c0+N+3.
  - `gnt` is high c1..c3+N.
- Back-to-back jobs: minimum one IDLE cycle between DONE and the next LOAD.
- Simultaneous `req`=2'b11 in IDLE: the winner is opposite the pointer. Requesters held high alternate strictly.
- Timeout job: COUNT lasts 2**WIDTH cycles, then DONE with `err`=1.

## Test plan
- Up job: after reset, req0 with start0=3, target0=7, dir0=1 → `gnt`=01 c1..c7; `load`=1 with `data_in`=3 in c1; `done`=01, `err`=0 in c7; `data_in`=7 in c7.
- Down wrap: req1 with start1=2, target1=14, dir1=0 → `dout` runs 2,1,0,15,14; `done`=10 in c7; park=14 afterwards.
- Zero-step job: start=target=5 → COUNT lasts one cycle; `done` in c3.
- Contention: `req`=11 held from reset → grants go 0,1,0,1; each gap has one IDLE cycle; operands of the losing requester are not latched until its own grant.
- Timeout: counter model with `dout` stuck at 0, job target 9 → 16 COUNT cycles, then `done` with `err`=1 in c18.
- Reset mid-COUNT: assert `rstn`=0 in c4 of a 10-step job → `gnt`=0 and `done`=0 immediately; `load`=1 with `data_in`=0; after release, a fresh job completes normally.
